// File: rtl/board_ctrl.sv
// board_ctrl: tic-tac-toe board controller on the responder end of the move interface.
// It validates moves, writes the 3x3 cell array, detects a win or a draw, and owns `turn`.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   update_loc  target cell index 0..8, row-major
//   update_val  cell value to write (0 empty, 1 X, 2 O)
//   submit      move strobe (level; one event per rising level)
//   reset       synchronous new-game request
//   turn        side to move (0 player, 1 AI)
//   board       flat cell array, cell i at bits [2i+1:2i]
//   move_count  accepted moves this game, 0..9
//   ack         one-cycle pulse, move accepted
//   err         one-cycle pulse, move rejected
//   game_over   high from game end until reset
//   winner      winning mark, 0 on draw or while in play
module board_ctrl #(
    parameter logic        FIRST_TURN = 1'b0,
    parameter int unsigned CELLS      = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           update_loc,
    input  logic [1:0]           update_val,
    input  logic                 submit,
    input  logic                 reset,
    output logic                 turn,
    output logic [2*CELLS-1:0]   board,
    output logic [3:0]           move_count,
    output logic                 ack,
    output logic                 err,
    output logic                 game_over,
    output logic [1:0]           winner
);

    typedef enum logic [1:0] {StIdle, StCheck, StOver} state_e;

    state_e             state_q, state_d;
    logic [2*CELLS-1:0] board_q, board_d;
    logic [3:0]         count_q, count_d;
    logic               turn_q, turn_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               over_q, over_d;
    logic [1:0]         win_q, win_d;
    logic               submit_s_q, submit_q, reset_s_q;
    logic               submit_s_d;

    logic               sub_edge;
    logic [1:0]         cell_cur;
    logic [1:0]         exp_val;
    logic               move_ok;
    logic [1:0]         line_win;

    function automatic logic [1:0] line_val(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
        return (a != 2'd0 && a == b && a == c) ? a : 2'd0;
    endfunction

    function automatic logic [1:0] find_winner(input logic [2*CELLS-1:0] b);
        logic [1:0] w;
        w = line_val(b[1:0], b[3:2], b[5:4]);
        if (w == 2'd0) w = line_val(b[7:6], b[9:8], b[11:10]);
        if (w == 2'd0) w = line_val(b[13:12], b[15:14], b[17:16]);
        if (w == 2'd0) w = line_val(b[1:0], b[7:6], b[13:12]);
        if (w == 2'd0) w = line_val(b[3:2], b[9:8], b[15:14]);
        if (w == 2'd0) w = line_val(b[5:4], b[11:10], b[17:16]);
        if (w == 2'd0) w = line_val(b[1:0], b[9:8], b[17:16]);
        if (w == 2'd0) w = line_val(b[5:4], b[9:8], b[13:12]);
        return w;
    endfunction

    // Unknown or floating submit counts as idle.
    assign submit_s_d = (submit === 1'b1);
    assign sub_edge   = submit_s_q & ~submit_q;
    assign exp_val    = (turn_q == 1'b0) ? 2'd1 : 2'd2;
    assign line_win   = find_winner(board_q);

    always_comb begin
        cell_cur = 2'd0;
        for (int i = 0; i < CELLS; i++) begin
            if (update_loc == i[3:0]) cell_cur = board_q[2*i +: 2];
        end
    end

    assign move_ok = (update_loc <= 4'd8) && (cell_cur == 2'd0) && (update_val == exp_val);

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        count_d = count_q;
        turn_d  = turn_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        over_d  = over_q;
        win_d   = win_q;
        if (reset_s_q) begin
            // New game wins over a coincident move event, which is dropped silently.
            state_d = StIdle;
            board_d = '0;
            count_d = 4'd0;
            turn_d  = FIRST_TURN;
            over_d  = 1'b0;
            win_d   = 2'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sub_edge) begin
                        if (move_ok) begin
                            for (int i = 0; i < CELLS; i++) begin
                                if (update_loc == i[3:0]) board_d[2*i +: 2] = update_val;
                            end
                            count_d = count_q + 4'd1;
                            ack_d   = 1'b1;
                            state_d = StCheck;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (line_win != 2'd0) begin
                        win_d   = line_win;
                        over_d  = 1'b1;
                        state_d = StOver;
                    end else if (count_q == 4'd9) begin
                        over_d  = 1'b1;
                        state_d = StOver;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = StIdle;
                    end
                end
                StOver: begin
                    if (sub_edge) err_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            board_q    <= '0;
            count_q    <= 4'd0;
            turn_q     <= FIRST_TURN;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            over_q     <= 1'b0;
            win_q      <= 2'd0;
            submit_s_q <= 1'b0;
            submit_q   <= 1'b0;
            reset_s_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            count_q    <= count_d;
            turn_q     <= turn_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            over_q     <= over_d;
            win_q      <= win_d;
            submit_s_q <= submit_s_d;
            submit_q   <= submit_s_q;
            reset_s_q  <= reset;
        end
    end

    assign turn       = turn_q;
    assign board      = board_q;
    assign move_count = count_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign game_over  = over_q;
    assign winner     = win_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Self-checking bench for board_ctrl: a game-level model is compared every cycle, plus
// hand-computed checkpoints after each directed scenario.
module tb_board_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  update_loc;
    logic [1:0]  update_val;
    logic        submit;
    logic        reset;
    logic        turn;
    logic [17:0] board;
    logic [3:0]  move_count;
    logic        ack;
    logic        err;
    logic        game_over;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    bit chk_en   = 0;

    board_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .update_loc (update_loc),
        .update_val (update_val),
        .submit     (submit),
        .reset      (reset),
        .turn       (turn),
        .board      (board),
        .move_count (move_count),
        .ack        (ack),
        .err        (err),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- game model ----------------
    int m_cell [9];
    int m_count, m_win;
    bit m_turn, m_over, m_ack, m_err, m_checking;
    bit m_sub1, m_sub0, m_rst1;

    function automatic int model_winner();
        for (int r = 0; r < 3; r++)
            if (m_cell[3*r] != 0 && m_cell[3*r] == m_cell[3*r+1] && m_cell[3*r] == m_cell[3*r+2])
                return m_cell[3*r];
        for (int c = 0; c < 3; c++)
            if (m_cell[c] != 0 && m_cell[c] == m_cell[c+3] && m_cell[c] == m_cell[c+6])
                return m_cell[c];
        if (m_cell[4] != 0 && m_cell[0] == m_cell[4] && m_cell[8] == m_cell[4]) return m_cell[4];
        if (m_cell[4] != 0 && m_cell[2] == m_cell[4] && m_cell[6] == m_cell[4]) return m_cell[4];
        return 0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b = b | (18'(m_cell[i]) << (2 * i));
        return b;
    endfunction

    task automatic model_new_game();
        for (int i = 0; i < 9; i++) m_cell[i] = 0;
        m_count = 0; m_win = 0; m_turn = 0; m_over = 0; m_checking = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit ev;
        int w;
        if (!rst_n) begin
            model_new_game();
            m_ack = 0; m_err = 0; m_sub1 = 0; m_sub0 = 0; m_rst1 = 0;
        end else begin
            ev = m_sub1 && !m_sub0;
            m_ack = 0;
            m_err = 0;
            if (m_rst1) begin
                model_new_game();
            end else if (m_checking) begin
                m_checking = 0;
                w = model_winner();
                if (w != 0) begin
                    m_win = w; m_over = 1;
                end else if (m_count == 9) begin
                    m_over = 1;
                end else begin
                    m_turn = !m_turn;
                end
            end else if (ev) begin
                if (m_over) begin
                    m_err = 1;
                end else if (update_loc <= 8 && m_cell[update_loc] == 0 &&
                             int'(update_val) == (m_turn ? 2 : 1)) begin
                    m_cell[update_loc] = int'(update_val);
                    m_count++;
                    m_ack = 1;
                    m_checking = 1;
                end else begin
                    m_err = 1;
                end
            end
            m_sub0 = m_sub1;
            m_sub1 = (submit === 1'b1);
            m_rst1 = reset;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [27:0] exp_v, act_v;
        if (ack) ack_cnt++;
        if (err) err_cnt++;
        if (chk_en) begin
            exp_v = {m_turn, model_board(), 4'(m_count), m_ack, m_err, m_over, 2'(m_win)};
            act_v = {turn, board, move_count, ack, err, game_over, winner};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model: got %07h expected %07h at %0t", act_v, exp_v, $time);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic move(input logic [3:0] loc, input logic [1:0] val);
        @(posedge clk); #1;
        update_loc = loc; update_val = val; submit = 1'b1;
        @(posedge clk); #1;
        submit = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic game_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
    endtask

    int a0, e0;
    int seq_loc [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        rst_n = 1'b0; reset = 1'b0; submit = 1'b0; update_loc = 4'd0; update_val = 2'd0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("reset_board", 32'(board), 0);
        check("reset_count", 32'(move_count), 0);
        check("reset_turn", 32'(turn), 0);
        check("reset_over", 32'({game_over, winner, ack, err}), 0);

        // First move with cycle-level timing.
        @(posedge clk); #1 update_loc = 4'd0; update_val = 2'd1; submit = 1'b1;
        @(posedge clk); #1 submit = 1'b0;
        @(negedge clk);
        check("ack_not_yet", 32'(ack), 0);
        @(negedge clk);
        check("first_ack", 32'(ack), 1);
        check("first_board", 32'(board), 32'h1);
        check("first_count", 32'(move_count), 1);
        check("turn_not_yet", 32'(turn), 0);
        @(negedge clk);
        check("ack_single", 32'(ack), 0);
        check("turn_toggled", 32'(turn), 1);
        repeat (2) @(negedge clk); #1;

        // Rejected moves.
        e0 = err_cnt; a0 = ack_cnt;
        move(4'd0, 2'd2);
        check("err_occupied", 32'(err_cnt - e0), 1);
        move(4'd9, 2'd2);
        check("err_loc9", 32'(err_cnt - e0), 2);
        move(4'd4, 2'd1);
        check("err_wrong_side", 32'(err_cnt - e0), 3);
        check("rej_no_ack", 32'(ack_cnt - a0), 0);
        check("rej_board", 32'(board), 32'h1);
        check("rej_turn", 32'(turn), 1);

        // Player row win.
        game_reset();
        check("newgame_turn", 32'(turn), 0);
        move(4'd0, 2'd1); move(4'd3, 2'd2); move(4'd1, 2'd1); move(4'd4, 2'd2);
        move(4'd2, 2'd1);
        check("win_winner", 32'(winner), 1);
        check("win_over", 32'(game_over), 1);
        check("win_turn", 32'(turn), 0);
        check("win_board", 32'(board), 32'h295);
        e0 = err_cnt;
        move(4'd5, 2'd2);
        check("over_err", 32'(err_cnt - e0), 1);
        check("over_board", 32'(board), 32'h295);

        // Draw.
        game_reset();
        for (int i = 0; i < 9; i++) move(4'(seq_loc[i]), (i % 2 == 0) ? 2'd1 : 2'd2);
        check("draw_count", 32'(move_count), 9);
        check("draw_over", 32'(game_over), 1);
        check("draw_winner", 32'(winner), 0);
        check("draw_board", 32'(board), 32'h16A59);

        // Held submit spans the accept and CHECK cycles: one event only.
        game_reset();
        a0 = ack_cnt; e0 = err_cnt;
        @(posedge clk); #1 update_loc = 4'd4; update_val = 2'd1; submit = 1'b1;
        repeat (10) @(posedge clk);
        #1 submit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("held_ack", 32'(ack_cnt - a0), 1);
        check("held_err", 32'(err_cnt - e0), 0);
        check("held_count", 32'(move_count), 1);
        check("held_board", 32'(board), 32'h100);
        check("held_turn", 32'(turn), 1);

        // Reset with a coincident valid submit edge.
        a0 = ack_cnt; e0 = err_cnt;
        @(posedge clk); #1 reset = 1'b1; update_loc = 4'd8; update_val = 2'd2; submit = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 submit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rprio_ack", 32'(ack_cnt - a0), 0);
        check("rprio_err", 32'(err_cnt - e0), 0);
        check("rprio_board", 32'(board), 0);
        check("rprio_count", 32'(move_count), 0);
        check("rprio_turn", 32'(turn), 0);

        // Async reset while in CHECK.
        @(posedge clk); #1 update_loc = 4'd0; update_val = 2'd1; submit = 1'b1;
        @(posedge clk); #1 submit = 1'b0;
        @(posedge clk); #2;
        check("pre_async_ack", 32'(ack), 1);
        rst_n = 1'b0;
        #1;
        check("async_outputs", 32'({turn, board, move_count, ack, err, game_over, winner}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("post_async_count", 32'(move_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
